// File: rtl/post_cov_pkg.sv
// Shared FSM encoding, fixed-point constants and round/saturate helpers for post_cov_gen.
// The helpers work on 64-bit signed values, so N must stay at 30 or below.
package post_cov_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_PHASE_A = 3'd2;
  localparam logic [2:0] ST_PHASE_B = 3'd3;
  localparam logic [2:0] ST_SYMM    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } rs_t;

  function automatic logic signed [63:0] s_one(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  function automatic int fidx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

  function automatic rs_t sat_n(input logic signed [63:0] x, input int n);
    rs_t                res;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi      = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (n - 1));
    res.sat = 1'b1;
    if (x > hi)      res.val = hi;
    else if (x < lo) res.val = lo;
    else begin
      res.val = x;
      res.sat = 1'b0;
    end
    return res;
  endfunction

  // Round half up toward +inf, then clamp to the N-bit signed range.
  function automatic rs_t round_sat(input logic signed [63:0] x, input int n, input int frac);
    return sat_n((x + (64'sd1 <<< (frac - 1))) >>> frac, n);
  endfunction

endpackage

// File: rtl/cov_dot_lane.sv
// cov_dot_lane: combinational DIM-lane signed dot product, rounded and saturated to N bits.
// Zero latency and no handshake; the caller registers o_res and o_sat.
module cov_dot_lane
  import post_cov_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int DIM  = 2
) (
  input  logic [DIM*N-1:0] i_a,
  input  logic [DIM*N-1:0] i_b,
  output logic [N-1:0]     o_res,
  output logic             o_sat
);

  localparam int PW = 2 * N;
  localparam int AW = 2 * N + $clog2(DIM) + 1;

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_acc;
  rs_t                  w_rs;
  logic                 w_unused_hi;

  always_comb begin
    w_prod = '0;
    w_acc  = '0;
    for (int j = 0; j < DIM; j++) begin
      w_prod = PW'($signed(i_a[j*N +: N])) * PW'($signed(i_b[j*N +: N]));
      w_acc  = w_acc + AW'(w_prod);
    end
    w_rs = round_sat(64'(w_acc), N, FRAC);
  end

  assign o_res       = w_rs.val[N-1:0];
  assign o_sat       = w_rs.sat;
  assign w_unused_hi = ^w_rs.val[63:N];

endmodule

// File: rtl/post_cov_gen.sv
// post_cov_gen: P_post = (I - K*H) * P_prior, one element per cycle; done 2*DIM*DIM+1 edges after accept.
// No backpressure: start is ignored unless idle. POST_COV_SYMM_EN adds a 1-cycle symmetrising step.
module post_cov_gen
  import post_cov_pkg::*;
#(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int DIM  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM*DIM*N-1:0] k_flat,
  input  logic [DIM*DIM*N-1:0] h_flat,
  input  logic [DIM*DIM*N-1:0] p_prior_flat,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [DIM*DIM*N-1:0] p_post_flat
);

  localparam int              IW   = $clog2(DIM);
  localparam int              MW   = DIM * DIM * N;
  localparam logic [IW-1:0]   LAST = IW'(DIM - 1);

  logic [2:0]    r_state;
  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;
  logic [MW-1:0] r_k;
  logic [MW-1:0] r_h;
  logic [MW-1:0] r_p;
  logic [MW-1:0] r_m;
  logic [MW-1:0] r_out;
  logic          r_ovf;

  int                  w_ri;
  int                  w_ci;
  logic [DIM*N-1:0]    w_a;
  logic [DIM*N-1:0]    w_b;
  logic [N-1:0]        w_lane_res;
  logic                w_lane_sat;
  logic signed [N:0]   w_diff;
  rs_t                 w_m_rs;
  logic [N-1:0]        w_m_val;
  logic                w_m_sat;
  logic                w_last;
  logic                w_unused_hi;

  // Phase A feeds row r of K with column c of H; phase B row r of M with column c of P.
  always_comb begin
    w_ri = int'(r_row);
    w_ci = int'(r_col);
    w_a  = '0;
    w_b  = '0;
    for (int j = 0; j < DIM; j++) begin
      if (r_state == ST_PHASE_A) begin
        w_a[j*N +: N] = r_k[fidx(w_ri, j, DIM)*N +: N];
        w_b[j*N +: N] = r_h[fidx(j, w_ci, DIM)*N +: N];
      end else begin
        w_a[j*N +: N] = r_m[fidx(w_ri, j, DIM)*N +: N];
        w_b[j*N +: N] = r_p[fidx(j, w_ci, DIM)*N +: N];
      end
    end
  end

  cov_dot_lane #(
    .N    (N),
    .FRAC (FRAC),
    .DIM  (DIM)
  ) u_lane (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_res (w_lane_res),
    .o_sat (w_lane_sat)
  );

  always_comb begin
    w_diff = ((w_ri == w_ci) ? (N+1)'(s_one(FRAC)) : '0) - (N+1)'($signed(w_lane_res));
    w_m_rs = sat_n(64'(w_diff), N);
  end

  assign w_m_val     = w_m_rs.val[N-1:0];
  assign w_m_sat     = w_m_rs.sat;
  assign w_unused_hi = ^w_m_rs.val[63:N];
  assign w_last      = (r_row == LAST) && (r_col == LAST);

`ifdef POST_COV_SYMM_EN
  logic [MW-1:0]     w_symm;
  logic signed [N:0] w_sum;

  // Floor average of each mirrored pair; N+1 bits cannot overflow, so no saturation.
  always_comb begin
    w_symm = r_out;
    w_sum  = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int j = i + 1; j < DIM; j++) begin
        w_sum = (N+1)'($signed(r_out[fidx(i, j, DIM)*N +: N]))
              + (N+1)'($signed(r_out[fidx(j, i, DIM)*N +: N]));
        w_symm[fidx(i, j, DIM)*N +: N] = w_sum[N:1];
        w_symm[fidx(j, i, DIM)*N +: N] = w_sum[N:1];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_h     <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k     <= k_flat;
            r_h     <= h_flat;
            r_p     <= p_prior_flat;
            r_ovf   <= 1'b0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_row   <= '0;
          r_col   <= '0;
          r_state <= ST_PHASE_A;
        end
        ST_PHASE_A, ST_PHASE_B: begin
          if (r_state == ST_PHASE_A) begin
            r_m[fidx(w_ri, w_ci, DIM)*N +: N] <= w_m_val;
            r_ovf <= r_ovf | w_lane_sat | w_m_sat;
          end else begin
            r_out[fidx(w_ri, w_ci, DIM)*N +: N] <= w_lane_res;
            r_ovf <= r_ovf | w_lane_sat;
          end
          if (w_last) begin
            r_row <= '0;
            r_col <= '0;
            if (r_state == ST_PHASE_A) r_state <= ST_PHASE_B;
`ifdef POST_COV_SYMM_EN
            else r_state <= ST_SYMM;
`else
            else r_state <= ST_DONE;
`endif
          end else if (r_col == LAST) begin
            r_col <= '0;
            r_row <= r_row + IW'(1);
          end else begin
            r_col <= r_col + IW'(1);
          end
        end
`ifdef POST_COV_SYMM_EN
        ST_SYMM: begin
          r_out   <= w_symm;
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == ST_LOAD) || (r_state == ST_PHASE_A) ||
                       (r_state == ST_PHASE_B) || (r_state == ST_SYMM);
  assign done        = (r_state == ST_DONE);
  assign ovf         = r_ovf;
  assign p_post_flat = r_out;

endmodule

// File: tb/tb_post_cov_gen.sv
// Bench for post_cov_gen with DIM=2 and DIM=3 instances: directed table, random runs against
// a matrix-level reference model, and hand-written restart / mid-run reset sequences.
module tb_post_cov_gen;

  localparam int     N    = 20;
  localparam int     FRAC = 10;
  localparam longint S    = longint'(1) <<< FRAC;
  localparam longint MAXV = (longint'(1) <<< (N - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N - 1));
`ifdef POST_COV_SYMM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef longint mat_t [4][4];
  typedef struct {
    int   dim;
    mat_t k;
    mat_t h;
    mat_t p;
    mat_t exp_p;
    bit   exp_ovf;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start2, start3;
  logic [4*N-1:0] k2, h2, p2, post2;
  logic [9*N-1:0] k3, h3, p3, post3;
  logic           busy2, done2, ovf2, busy3, done3, ovf3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  post_cov_gen #(.N(N), .FRAC(FRAC), .DIM(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .k_flat(k2), .h_flat(h2), .p_prior_flat(p2),
    .busy(busy2), .done(done2), .ovf(ovf2), .p_post_flat(post2)
  );

  post_cov_gen #(.N(N), .FRAC(FRAC), .DIM(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .k_flat(k3), .h_flat(h3), .p_prior_flat(p3),
    .busy(busy3), .done(done3), .ovf(ovf3), .p_post_flat(post3)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint rnd(input longint x);
    return (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
  endfunction

  function automatic longint sat(input longint x, inout bit o);
    if (x > MAXV) begin o = 1'b1; return MAXV; end
    if (x < MINV) begin o = 1'b1; return MINV; end
    return x;
  endfunction

  // Reference: M = I*S - K*H, P_post = M*P, each stage rounded and clamped.
  task automatic model(input int dim, input mat_t k, input mat_t h, input mat_t p,
                       output mat_t o, output bit ov);
    mat_t   m;
    longint acc;
    longint avg;
    ov = 1'b0;
    m  = '{default: 0};
    o  = '{default: 0};
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) begin
        acc = 0;
        for (int j = 0; j < dim; j++) acc += k[r][j] * h[j][c];
        m[r][c] = sat(((r == c) ? S : 0) - sat(rnd(acc), ov), ov);
      end
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) begin
        acc = 0;
        for (int j = 0; j < dim; j++) acc += m[r][j] * p[j][c];
        o[r][c] = sat(rnd(acc), ov);
      end
`ifdef POST_COV_SYMM_EN
    for (int i = 0; i < dim; i++)
      for (int j = i + 1; j < dim; j++) begin
        avg = (o[i][j] + o[j][i]) >>> 1;
        o[i][j] = avg;
        o[j][i] = avg;
      end
`else
    avg = 0;
`endif
  endtask

  function automatic logic [16*N-1:0] pack(input mat_t m, input int dim);
    logic [16*N-1:0] v;
    v = '0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) v[(r*dim+c)*N +: N] = m[r][c][N-1:0];
    return v;
  endfunction

  task automatic apply_ops(input int dim, input mat_t k, input mat_t h, input mat_t p);
    logic [16*N-1:0] vk, vh, vp;
    vk = pack(k, dim);
    vh = pack(h, dim);
    vp = pack(p, dim);
    if (dim == 2) begin
      k2 = vk[4*N-1:0]; h2 = vh[4*N-1:0]; p2 = vp[4*N-1:0];
    end else begin
      k3 = vk[9*N-1:0]; h3 = vh[9*N-1:0]; p3 = vp[9*N-1:0];
    end
  endtask

  task automatic set_start(input int dim, input logic v);
    if (dim == 2) start2 = v; else start3 = v;
  endtask

  function automatic logic get_busy(input int dim);
    return (dim == 2) ? busy2 : busy3;
  endfunction

  function automatic logic get_done(input int dim);
    return (dim == 2) ? done2 : done3;
  endfunction

  function automatic logic get_ovf(input int dim);
    return (dim == 2) ? ovf2 : ovf3;
  endfunction

  function automatic longint elem(input int dim, input int r, input int c);
    logic signed [N-1:0] b;
    if (dim == 2) b = post2[(r*2+c)*N +: N];
    else          b = post3[(r*3+c)*N +: N];
    return longint'(b);
  endfunction

  task automatic check_result(input int dim, input mat_t e, input bit eo, input string tag);
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        check($sformatf("%s p[%0d][%0d]", tag, r, c), elem(dim, r, c), e[r][c]);
    check($sformatf("%s ovf", tag), longint'(get_ovf(dim)), longint'(eo));
  endtask

  task automatic set_diag(output mat_t m, input longint d);
    m = '{default: 0};
    for (int i = 0; i < 4; i++) m[i][i] = d;
  endtask

  task automatic rand_mat(output mat_t m, input int dim, input int maxbits);
    int mb;
    m = '{default: 0};
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++) begin
        mb = $urandom_range(2, maxbits);
        m[r][c] = longint'($urandom_range(0, 32'd1 << (mb + 1))) - (longint'(1) <<< mb);
      end
  endtask

  // One start pulse, then follow busy/done edge by edge with a bounded wait.
  task automatic run_vec(input int dim, input mat_t k, input mat_t h, input mat_t p,
                         input mat_t e, input bit eo, input string tag);
    mat_t junk;
    int   lat;
    bit   busy_ok;
    @(negedge clk);
    apply_ops(dim, k, h, p);
    set_start(dim, 1'b1);
    @(posedge clk);
    #1;
    set_start(dim, 1'b0);
    rand_mat(junk, dim, 12);
    apply_ops(dim, junk, junk, junk);
    busy_ok = get_busy(dim);
    lat = -1;
    for (int ed = 1; ed <= 60 && lat < 0; ed++) begin
      @(posedge clk);
      #1;
      if (get_done(dim)) begin
        lat = ed;
        if (get_busy(dim)) busy_ok = 1'b0;
      end else if (!get_busy(dim)) busy_ok = 1'b0;
    end
    check($sformatf("%s latency", tag), lat, 2*dim*dim + 1 + EXTRA);
    check($sformatf("%s busy window", tag), longint'(busy_ok), 1);
    check_result(dim, e, eo, tag);
    @(posedge clk);
    #1;
    check($sformatf("%s done width", tag), longint'(get_done(dim)), 0);
    check($sformatf("%s busy after", tag), longint'(get_busy(dim)), 0);
  endtask

  vec_t tbl[5];

  initial begin
    mat_t m, rk, rh, rp, re, zk, altp;
    bit   reo;
    int   dim, lat, pulses;

    rst_n = 1'b0;
    start2 = 1'b0; start3 = 1'b0;
    k2 = '0; h2 = '0; p2 = '0;
    k3 = '0; h3 = '0; p3 = '0;
    #2;
    check("reset busy", longint'(busy2 | busy3), 0);
    check("reset done", longint'(done2 | done3), 0);
    check("reset ovf", longint'(ovf2 | ovf3), 0);
    check("reset p_post nonzero", longint'((post2 != '0) || (post3 != '0)), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tbl[0].dim = 2; set_diag(m, 512);  tbl[0].k = m; set_diag(m, 1024); tbl[0].h = m;
    tbl[0].p = m;   set_diag(m, 512);  tbl[0].exp_p = m; tbl[0].exp_ovf = 1'b0;
    tbl[1].dim = 3; set_diag(m, 256);  tbl[1].k = m; set_diag(m, 1024); tbl[1].h = m;
    set_diag(m, 2048); tbl[1].p = m;   set_diag(m, 1536); tbl[1].exp_p = m; tbl[1].exp_ovf = 1'b0;
    tbl[2].dim = 2; set_diag(m, -4096); tbl[2].k = m; set_diag(m, 1024); tbl[2].h = m;
    set_diag(m, 204800); tbl[2].p = m; set_diag(m, 524287); tbl[2].exp_p = m; tbl[2].exp_ovf = 1'b1;
    tbl[3].dim = 2; set_diag(m, 0); tbl[3].k = m; set_diag(m, 1024); tbl[3].h = m;
    m = '{default: 0}; m[0][0] = 300; m[0][1] = -7; m[1][0] = -7; m[1][1] = 5000;
    tbl[3].p = m; tbl[3].exp_p = m; tbl[3].exp_ovf = 1'b0;
    tbl[4].dim = 2; set_diag(m, 0); m[0][1] = 512; tbl[4].k = m;
    set_diag(m, 1024); tbl[4].h = m; tbl[4].p = m;
`ifdef POST_COV_SYMM_EN
    m[0][1] = -256; m[1][0] = -256;
`else
    m[0][1] = -512; m[1][0] = 0;
`endif
    tbl[4].exp_p = m; tbl[4].exp_ovf = 1'b0;

    for (int i = 0; i < 5; i++)
      run_vec(tbl[i].dim, tbl[i].k, tbl[i].h, tbl[i].p, tbl[i].exp_p, tbl[i].exp_ovf,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 15; i++) begin
      dim = (i % 3 == 2) ? 3 : 2;
      rand_mat(rk, dim, 14);
      rand_mat(rh, dim, 14);
      rand_mat(rp, dim, 18);
      model(dim, rk, rh, rp, re, reo);
      run_vec(dim, rk, rh, rp, re, reo, $sformatf("rand%0d", i));
    end

    // Second start at edge 3 with other operands must be ignored.
    set_diag(zk, 0);
    set_diag(altp, 777);
    @(negedge clk);
    apply_ops(2, tbl[0].k, tbl[0].h, tbl[0].p);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = -1;
    pulses = 0;
    for (int ed = 1; ed <= 30; ed++) begin
      if (ed == 3) begin
        apply_ops(2, zk, tbl[0].h, altp);
        start2 = 1'b1;
      end else start2 = 1'b0;
      @(posedge clk);
      #1;
      if (done2) begin
        pulses++;
        if (lat < 0) begin
          lat = ed;
          check_result(2, tbl[0].exp_p, 1'b0, "restart");
        end
      end
    end
    check("restart latency", lat, 9 + EXTRA);
    check("restart done pulses", pulses, 1);

    // Asynchronous reset mid-run, then a clean run.
    @(negedge clk);
    apply_ops(2, tbl[4].k, tbl[4].h, tbl[4].p);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset busy", longint'(busy2), 0);
    check("midreset done", longint'(done2), 0);
    check("midreset ovf", longint'(ovf2), 0);
    check("midreset p_post nonzero", longint'(post2 != '0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(2, tbl[4].k, tbl[4].h, tbl[4].p, tbl[4].exp_p, tbl[4].exp_ovf, "postreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
